// File: rtl/alu_cmd_driver.sv
// Valid/ready command front end for the combinational ALU: drives the operands, waits a settle time,
// then queues {result, carry, select} in a show-ahead response FIFO. Optional ALU_CMD_DRIVER_CHECK_EN adds a result checker.
module alu_cmd_driver #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SEL_W         = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned DEPTH         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_carry,
    output logic [SEL_W-1:0] rsp_sel,
    output logic             busy,
    output logic [15:0]      done_cnt
`ifdef ALU_CMD_DRIVER_CHECK_EN
    ,
    output logic             mismatch,
    output logic [7:0]       err_cnt
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned DONE_W = 16;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             carry;
        logic [SEL_W-1:0] sel;
    } rsp_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    rsp_t              mem_q [DEPTH];
    rsp_t              mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic [DONE_W-1:0] done_cnt_q, done_cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              push;
    logic              pop;

    // Next-state: command FSM, FIFO bookkeeping and the registered handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        done_cnt_d  = done_cnt_q;
        push        = 1'b0;
        pop         = rsp_ready && rsp_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    push       = 1'b1;
                    done_cnt_d = done_cnt_q + DONE_W'(1);
                    state_d    = ST_IDLE;
                end
            end
        endcase

        // Slot was reserved at accept, so a push always has room.
        if (push) begin
            mem_d[wr_ptr_q] = '{out: alu_out, carry: alu_carry, sel: alu_sel_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        rsp_valid_d = (count_d != '0);
        busy_d      = (state_d == ST_WAIT);
        cmd_ready_d = (state_d == ST_IDLE) && (count_d < OCC_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            done_cnt_q  <= done_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = mem_q[rd_ptr_q].out;
    assign rsp_carry = mem_q[rd_ptr_q].carry;
    assign rsp_sel   = mem_q[rd_ptr_q].sel;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;

`ifdef ALU_CMD_DRIVER_CHECK_EN
    logic [WIDTH:0]   chk_sum;
    logic [WIDTH-1:0] chk_out;
    logic             chk_modelled;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    // Reference ALU; carry is always the unsigned add carry-out regardless of select.
    always_comb begin
        chk_sum      = {1'b0, alu_a_q} + {1'b0, alu_b_q};
        chk_out      = '0;
        chk_modelled = 1'b1;
        case (alu_sel_q)
            SEL_W'(4'b0000): chk_out = chk_sum[WIDTH-1:0];
            SEL_W'(4'b0001): chk_out = alu_a_q - alu_b_q;
            SEL_W'(4'b1000): chk_out = alu_a_q & alu_b_q;
            SEL_W'(4'b1001): chk_out = alu_a_q | alu_b_q;
            SEL_W'(4'b1010): chk_out = alu_a_q ^ alu_b_q;
            SEL_W'(4'b1011): chk_out = ~(alu_a_q | alu_b_q);
            SEL_W'(4'b1100): chk_out = ~(alu_a_q & alu_b_q);
            SEL_W'(4'b1101): chk_out = ~(alu_a_q ^ alu_b_q);
            default:         chk_modelled = 1'b0;
        endcase

        mismatch_d = push && chk_modelled &&
                     ((alu_out != chk_out) || (alu_carry != chk_sum[WIDTH]));
        err_cnt_d  = err_cnt_q;
        if (mismatch_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: SETTLE_CYCLES=1 and 3 instances, each fed by a behavioural ALU.
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       force_bad = 1'b0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [3:0] cmd_sel = '0;
    int         tests = 0;
    int         fails = 0;

    logic       cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_carry, busy, alu_carry;
    logic [7:0] alu_a, alu_b, alu_out, rsp_out;
    logic [3:0] alu_sel, rsp_sel;
    logic [15:0] done_cnt;
    logic [8:0] alu_res;

    logic       cmd_valid3 = 1'b0, rsp_ready3 = 1'b0;
    logic       cmd_ready3, rsp_valid3, rsp_carry3, busy3, alu_carry3;
    logic [7:0] alu_a3, alu_b3, alu_out3, rsp_out3;
    logic [3:0] alu_sel3, rsp_sel3;
    logic [15:0] done_cnt3;
    logic [8:0] alu_res3;

`ifdef ALU_CMD_DRIVER_CHECK_EN
    logic       mismatch, mismatch3;
    logic [7:0] err_cnt, err_cnt3;
`endif

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        logic [8:0] sum;
        logic [7:0] r;
        sum = {1'b0, a} + {1'b0, b};
        case (s)
            4'b0001: r = a - b;
            4'b1000: r = a & b;
            4'b1001: r = a | b;
            4'b1010: r = a ^ b;
            4'b1011: r = ~(a | b);
            4'b1100: r = ~(a & b);
            4'b1101: r = ~(a ^ b);
            default: r = sum[7:0];
        endcase
        return {sum[8], r};
    endfunction

    assign alu_res   = alu_f(alu_a, alu_b, alu_sel);
    assign alu_out   = force_bad ? 8'h55 : alu_res[7:0];
    assign alu_carry = alu_res[8];
    assign alu_res3  = alu_f(alu_a3, alu_b3, alu_sel3);
    assign alu_out3  = alu_res3[7:0];
    assign alu_carry3 = alu_res3[8];

    alu_cmd_driver #(.WIDTH(8), .SEL_W(4), .SETTLE_CYCLES(1), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_sel(rsp_sel),
        .busy(busy), .done_cnt(done_cnt)
`ifdef ALU_CMD_DRIVER_CHECK_EN
        , .mismatch(mismatch), .err_cnt(err_cnt)
`endif
    );

    alu_cmd_driver #(.WIDTH(8), .SEL_W(4), .SETTLE_CYCLES(3), .DEPTH(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_out(alu_out3), .alu_carry(alu_carry3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_out(rsp_out3), .rsp_carry(rsp_carry3), .rsp_sel(rsp_sel3),
        .busy(busy3), .done_cnt(done_cnt3)
`ifdef ALU_CMD_DRIVER_CHECK_EN
        , .mismatch(mismatch3), .err_cnt(err_cnt3)
`endif
    );

    // Presents a command to u_dut; returns at accept edge + 1 time unit.
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, output bit ok);
        cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready got %0b want 0", cmd_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0b want 0", busy); end
        tests++; if (done_cnt !== 16'd0) begin fails++; $display("FAIL rst_done_cnt got %0h want 0", done_cnt); end
        tests++; if ({alu_a, alu_b, alu_sel} !== 20'h0) begin fails++; $display("FAIL rst_alu got %0h want 0", {alu_a, alu_b, alu_sel}); end
        tests++; if ({rsp_out, rsp_carry, rsp_sel} !== 13'h0) begin fails++; $display("FAIL rst_rsp got %0h want 0", {rsp_out, rsp_carry, rsp_sel}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_cmd_ready got %0b want 1", cmd_ready); end
    endtask

    task automatic test_add_carry();
        bit ok;
        send_cmd(8'hFF, 8'h01, 4'b0000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL add_accept timed out"); end
        tests++; if ({rsp_valid, busy} !== 2'b01) begin fails++; $display("FAIL add_wait valid/busy got %b want 01", {rsp_valid, busy}); end
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL add_rsp_valid got %0b want 1", rsp_valid); end
        tests++; if (rsp_out !== 8'h00) begin fails++; $display("FAIL add_rsp_out got %0h want 00", rsp_out); end
        tests++; if (rsp_carry !== 1'b1) begin fails++; $display("FAIL add_rsp_carry got %0b want 1", rsp_carry); end
        tests++; if (rsp_sel !== 4'b0000) begin fails++; $display("FAIL add_rsp_sel got %b want 0000", rsp_sel); end
        tests++; if (done_cnt !== 16'd1) begin fails++; $display("FAIL add_done_cnt got %0d want 1", done_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL add_busy got %0b want 0", busy); end
        tests++; if (alu_a !== 8'hFF) begin fails++; $display("FAIL add_alu_a_held got %0h want ff", alu_a); end
        pop_one();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_pop got rsp_valid %0b want 0", rsp_valid); end
    endtask

    task automatic test_nand();
        bit ok;
        send_cmd(8'hF0, 8'h3C, 4'b1100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL nand_accept timed out"); end
        @(posedge clk); #1;
        tests++; if ({rsp_valid, rsp_out, rsp_carry, rsp_sel} !== {1'b1, 8'hCF, 1'b1, 4'b1100})
            begin fails++; $display("FAIL nand_rsp got %0h want %0h", {rsp_valid, rsp_out, rsp_carry, rsp_sel}, {1'b1, 8'hCF, 1'b1, 4'b1100}); end
        pop_one();
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1; rsp_ready = 1'b0;
        tests++; if ({rsp_valid, done_cnt} !== {1'b0, 16'd2}) begin fails++; $display("FAIL empty_pop valid/done got %0h want 00002", {rsp_valid, done_cnt}); end
    endtask

    task automatic test_backpressure();
        logic [7:0] ea [5];
        logic [7:0] eb [5];
        logic [3:0] es [5];
        logic [7:0] eo [5];
        logic       ec [5];
        bit ok;
        ea = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        eb = '{8'h01, 8'hF0, 8'h0F, 8'hFF, 8'hAA};
        es = '{4'b0000, 4'b1000, 4'b1001, 4'b1010, 4'b0001};
        eo = '{8'h12, 8'h20, 8'h3F, 8'hBB, 8'hAB};
        ec = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_cmd(ea[i], eb[i], es[i], ok);
            tests++; if (!ok) begin fails++; $display("FAIL bp_accept%0d timed out", i); end
        end
        @(posedge clk); #1;
        tests++; if ({cmd_ready, rsp_valid, rsp_out} !== {1'b0, 1'b1, eo[0]})
            begin fails++; $display("FAIL bp_full ready/valid/out got %0h want %0h", {cmd_ready, rsp_valid, rsp_out}, {1'b0, 1'b1, eo[0]}); end
        cmd_a = ea[4]; cmd_b = eb[4]; cmd_sel = es[4]; cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            tests++; if ({cmd_ready, busy} !== 2'b00) begin fails++; $display("FAIL bp_blocked%0d ready/busy got %b want 00", k, {cmd_ready, busy}); end
        end
        pop_one();
        tests++; if ({cmd_ready, rsp_out} !== {1'b1, eo[1]}) begin fails++; $display("FAIL bp_after_pop ready/out got %0h want %0h", {cmd_ready, rsp_out}, {1'b1, eo[1]}); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tests++; if ({busy, cmd_ready, alu_a} !== {2'b10, ea[4]}) begin fails++; $display("FAIL bp_fifth_accept busy/ready/alu_a got %0h want %0h", {busy, cmd_ready, alu_a}, {2'b10, ea[4]}); end
        @(posedge clk); #1;
        tests++; if (done_cnt !== 16'd7) begin fails++; $display("FAIL bp_done_cnt got %0d want 7", done_cnt); end
        for (int i = 1; i < 5; i++) begin
            tests++; if ({rsp_valid, rsp_out, rsp_carry, rsp_sel} !== {1'b1, eo[i], ec[i], es[i]})
                begin fails++; $display("FAIL bp_order%0d got %0h want %0h", i, {rsp_valid, rsp_out, rsp_carry, rsp_sel}, {1'b1, eo[i], ec[i], es[i]}); end
            pop_one();
        end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_drained rsp_valid got %0b want 0", rsp_valid); end
    endtask

    task automatic test_settle3();
        bit ok;
        ok = 1'b0;
        cmd_a = 8'h05; cmd_b = 8'h06; cmd_sel = 4'b0000; cmd_valid3 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready3 === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        cmd_a = 8'hAA; cmd_b = 8'hBB; cmd_sel = 4'b1111;
        tests++; if (!ok) begin fails++; $display("FAIL s3_accept timed out"); end
        for (int k = 0; k < 3; k++) begin
            tests++; if ({busy3, rsp_valid3, alu_a3, alu_b3, alu_sel3} !== {2'b10, 8'h05, 8'h06, 4'b0000})
                begin fails++; $display("FAIL s3_wait%0d got %0h want %0h", k, {busy3, rsp_valid3, alu_a3, alu_b3, alu_sel3}, {2'b10, 8'h05, 8'h06, 4'b0000}); end
            @(posedge clk); #1;
        end
        tests++; if ({busy3, rsp_valid3, rsp_out3, rsp_carry3, done_cnt3} !== {2'b01, 8'h0B, 1'b0, 16'd1})
            begin fails++; $display("FAIL s3_done got %0h want %0h", {busy3, rsp_valid3, rsp_out3, rsp_carry3, done_cnt3}, {2'b01, 8'h0B, 1'b0, 16'd1}); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_cmd(8'h01, 8'h02, 4'b0000, ok);
        @(posedge clk); #1;
        send_cmd(8'h03, 8'h04, 4'b0000, ok);
        tests++; if ({ok, busy, rsp_valid} !== 3'b111) begin fails++; $display("FAIL rm_setup ok/busy/valid got %b want 111", {ok, busy, rsp_valid}); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if ({rsp_valid, busy, cmd_ready, rsp_valid3} !== 4'b0000) begin fails++; $display("FAIL rm_flags got %b want 0000", {rsp_valid, busy, cmd_ready, rsp_valid3}); end
        tests++; if ({alu_a, alu_b, alu_sel, done_cnt} !== 36'h0) begin fails++; $display("FAIL rm_clear got %0h want 0", {alu_a, alu_b, alu_sel, done_cnt}); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({rsp_valid, done_cnt} !== {1'b0, 16'd0}) begin fails++; $display("FAIL rm_discard got %0h want 0", {rsp_valid, done_cnt}); end
        send_cmd(8'h12, 8'h34, 4'b0000, ok);
        @(posedge clk); #1;
        tests++; if ({ok, rsp_valid, rsp_out, done_cnt} !== {2'b11, 8'h46, 16'd1})
            begin fails++; $display("FAIL rm_after got %0h want %0h", {ok, rsp_valid, rsp_out, done_cnt}, {2'b11, 8'h46, 16'd1}); end
        pop_one();
    endtask

`ifdef ALU_CMD_DRIVER_CHECK_EN
    task automatic test_check();
        bit ok;
        force_bad = 1'b1;
        send_cmd(8'h10, 8'h20, 4'b0000, ok);
        tests++; if ({ok, mismatch} !== 2'b10) begin fails++; $display("FAIL chk_pre ok/mismatch got %b want 10", {ok, mismatch}); end
        @(posedge clk); #1;
        force_bad = 1'b0;
        tests++; if ({mismatch, err_cnt, rsp_out} !== {1'b1, 8'd1, 8'h55}) begin fails++; $display("FAIL chk_pulse got %0h want %0h", {mismatch, err_cnt, rsp_out}, {1'b1, 8'd1, 8'h55}); end
        @(posedge clk); #1;
        tests++; if ({mismatch, err_cnt} !== {1'b0, 8'd1}) begin fails++; $display("FAIL chk_single got %0h want 001", {mismatch, err_cnt}); end
        pop_one();
        send_cmd(8'h10, 8'h20, 4'b0000, ok);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tests++; if ({mismatch, err_cnt} !== {1'b0, 8'd1}) begin fails++; $display("FAIL chk_clean%0d got %0h want 001", k, {mismatch, err_cnt}); end
        end
        tests++; if (rsp_out !== 8'h30) begin fails++; $display("FAIL chk_clean_out got %0h want 30", rsp_out); end
        pop_one();
    endtask
`endif

    initial begin
        test_reset();
        test_add_carry();
        test_nand();
        test_backpressure();
        test_settle3();
        test_reset_mid();
`ifdef ALU_CMD_DRIVER_CHECK_EN
        test_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Sequential initiator for the combinational `alu` block (ports A, B, ALU_Sel, ALU_Out, CarryOut).
- Accepts operation commands over a valid/ready handshake and drives the operands and select into the ALU.
- Waits a programmable settle time, then captures ALU_Out/CarryOut into a response FIFO.
- Returns results over a second valid/ready handshake. It is the request/response front end that replaces ad-hoc operand pokes on the ALU interface.

Parameters:
- WIDTH, 8, operand and result width (ALU A/B/ALU_Out width).
- SEL_W, 4, ALU_Sel width.
- SETTLE_CYCLES, 1, clock edges between driving the ALU and capturing its outputs; legal range 1..15.
- DEPTH, 4, response FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_sel  input  SEL_W  ALU operation select.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_sel  output  SEL_W  to ALU ALU_Sel.
- alu_out  input  WIDTH  from ALU ALU_Out.
- alu_carry  input  1  from ALU CarryOut.
- rsp_valid  output  1  response available (FIFO not empty).
- rsp_ready  input  1  consumer takes response.
- rsp_out  output  WIDTH  captured ALU_Out.
- rsp_carry  output  1  captured CarryOut.
- rsp_sel  output  SEL_W  select that produced the response.
- busy  output  1  high in WAIT state.
- done_cnt  output  16  completed operations; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; alu_a/alu_b/alu_sel=0; FIFO empty.
  - rsp_valid=0; rsp_out/rsp_carry/rsp_sel=0; busy=0; done_cnt=0; cmd_ready=0 while rst_n=0.
  - Reset mid-WAIT discards the in-flight command; no response is produced.
- FSM states:
  - IDLE: cmd_ready = (fifo_count < DEPTH).
    - On accept at edge T: register cmd_a/b/sel into alu_a/b/sel, load cnt = SETTLE_CYCLES-1, go to WAIT.
  - WAIT: cmd_ready=0, busy=1. alu_* held stable.
    - While cnt != 0: decrement each edge.
    - At the edge with cnt == 0: push {alu_out, alu_carry, alu_sel} into the FIFO, done_cnt++, go to IDLE.
- Latency: with an empty FIFO, rsp_valid rises after edge T+SETTLE_CYCLES. Minimum command spacing is SETTLE_CYCLES+1 edges.
- alu_* outputs keep the last command's values in IDLE; they are not cleared.
- FIFO behaviour:
  - Show-ahead: rsp_* reflect the head entry whenever rsp_valid=1; head values are held while rsp_valid && !rsp_ready.
  - A slot is reserved at accept time (count < DEPTH), so a push never overflows.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Empty pop (rsp_ready with rsp_valid=0): ignored.
  - Full FIFO: cmd_ready=0 until a pop occurs; the pop edge frees the slot and cmd_ready rises the next cycle.
- cmd_* are sampled only at the accept edge; changes at other times are ignored.

Optional Feature:
- ALU_CMD_DRIVER_CHECK_EN:
  - When defined, adds output `mismatch` (1 bit, reset 0) and output `err_cnt` (8 bits, saturating at 8'hFF, reset 0).
  - At capture, an internal reference model computes the expected result from alu_a/alu_b/alu_sel:
    - Operations 0000 add, 0001 sub, 1000 and, 1001 or, 1010 xor, 1011 nor, 1100 nand, 1101 xnor: WIDTH-bit result.
    - Expected carry = bit WIDTH of ({1'b0,A}+{1'b0,B}) for every select.
  - If alu_out or alu_carry differs for a modelled select, `mismatch` pulses for one cycle and err_cnt increments.
  - Unmodelled selects are never flagged.
- Without the macro: neither port exists and there is no checking logic.

Test Plan:
- Add with carry: cmd_a=8'hFF, cmd_b=8'h01, cmd_sel=4'b0000, SETTLE_CYCLES=1 -> rsp_valid after edge T+1; rsp_out=8'h00, rsp_carry=1, rsp_sel=0000, done_cnt=1.
- NAND: cmd_a=8'hF0, cmd_b=8'h3C, cmd_sel=4'b1100 -> rsp_out=8'hCF, rsp_carry=1 (F0+3C=12C).
- Backpressure: rsp_ready=0, issue 5 back-to-back commands -> 4 accepted, cmd_ready stays 0 for the 5th.
  - Then assert rsp_ready for one cycle -> one pop; 5th accepted the following cycle; responses emerge in issue order.
- SETTLE_CYCLES=3: single command at edge T -> busy high for 3 cycles; rsp_valid after T+3; alu_a/b/sel stable throughout WAIT.
- Reset mid-op: accept a command, drop rst_n during WAIT -> immediately rsp_valid=0, alu_*=0, done_cnt=0.
  - After release, next command completes normally with done_cnt=1.
- With ALU_CMD_DRIVER_CHECK_EN: force alu_out to 8'h55 on an add of 8'h10+8'h20 -> mismatch pulses once, err_cnt=1.
  - An unforced add produces no pulse.
